// File: rtl/payment_ctrl.sv
// rtl/payment_ctrl.sv - coin payment session controller
// Collects coins against a latched price and reports success/failure with change.
module payment_ctrl #(
  parameter int TIMEOUT_TICKS = 30000000,
  parameter int PRICE_W       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pay_en,
  input  logic [PRICE_W-1:0] price_total,
  input  logic               coin_1,
  input  logic               coin_5,
  input  logic               coin_10,
  input  logic               cancel,
  output logic [PRICE_W-1:0] paid,
  output logic [PRICE_W-1:0] change,
  output logic               pay_ok,
  output logic               pay_fail,
  output logic               finish
);

  localparam int TIMER_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int SUM_W   = PRICE_W + 5;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_TICKS - 1);
  localparam logic [SUM_W-1:0]   PAID_MAX   = {5'b0, {PRICE_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OK,
    ST_FAIL
  } state_t;

  state_t               state, state_nxt;
  logic [PRICE_W-1:0]   due, due_nxt;
  logic [PRICE_W-1:0]   paid_nxt, change_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic                 ok_nxt, fail_nxt, finish_nxt;
  logic [SUM_W-1:0]     coin_sum, sum_ext;
  logic [PRICE_W-1:0]   paid_sat;
  logic                 any_coin;

  // Simultaneous coins all count; the running total clamps at full scale.
  always_comb begin
    coin_sum = (coin_1  ? SUM_W'(1)  : '0)
             + (coin_5  ? SUM_W'(5)  : '0)
             + (coin_10 ? SUM_W'(10) : '0);
    sum_ext  = {5'b0, paid} + coin_sum;
    paid_sat = (sum_ext > PAID_MAX) ? {PRICE_W{1'b1}} : sum_ext[PRICE_W-1:0];
    any_coin = coin_1 | coin_5 | coin_10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      due      <= '0;
      paid     <= '0;
      change   <= '0;
      timer    <= '0;
      pay_ok   <= 1'b0;
      pay_fail <= 1'b0;
      finish   <= 1'b0;
    end else begin
      state    <= state_nxt;
      due      <= due_nxt;
      paid     <= paid_nxt;
      change   <= change_nxt;
      timer    <= timer_nxt;
      pay_ok   <= ok_nxt;
      pay_fail <= fail_nxt;
      finish   <= finish_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    due_nxt    = due;
    paid_nxt   = paid;
    change_nxt = change;
    timer_nxt  = timer;
    ok_nxt     = pay_ok;
    fail_nxt   = pay_fail;
    finish_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        paid_nxt   = '0;
        change_nxt = '0;
        timer_nxt  = '0;
        ok_nxt     = 1'b0;
        fail_nxt   = 1'b0;
        if (pay_en) begin
          due_nxt   = price_total;
          state_nxt = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        paid_nxt  = paid_sat;
        timer_nxt = any_coin ? '0 : timer + TIMER_W'(1);
        // Exit decisions use the total including this cycle's coins.
        if (!pay_en) begin
          state_nxt = ST_IDLE;
          paid_nxt  = '0;
          timer_nxt = '0;
          due_nxt   = '0;
        end else if (cancel) begin
          state_nxt  = ST_FAIL;
          change_nxt = paid_sat;
          fail_nxt   = 1'b1;
          finish_nxt = 1'b1;
        end else if (paid_sat >= due) begin
          state_nxt  = ST_OK;
          change_nxt = paid_sat - due;
          ok_nxt     = 1'b1;
          finish_nxt = 1'b1;
        end else if (!any_coin && timer == TIMER_LAST) begin
          state_nxt  = ST_FAIL;
          change_nxt = paid_sat;
          fail_nxt   = 1'b1;
          finish_nxt = 1'b1;
        end
      end

      ST_OK, ST_FAIL: begin
        if (!pay_en) begin
          state_nxt  = ST_IDLE;
          due_nxt    = '0;
          paid_nxt   = '0;
          change_nxt = '0;
          timer_nxt  = '0;
          ok_nxt     = 1'b0;
          fail_nxt   = 1'b0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
